// File: rtl/ddr_pkg.sv
// Shared DDR definitions: command encodings, address layout, refresh interval
// and the arbiter state type. Used by the arbiter and the DDR controller.
package ddr_pkg;

  localparam int DDR_ADDR_W = 24;
  localparam int DDR_DATA_W = 32;
  localparam int DDR_BA_W   = 2;
  localparam int DDR_ROW_W  = 13;
  localparam int DDR_COL_W  = 9;

  // 7.8 us between auto-refreshes at 133 MHz
  localparam int DDR_REFRESH_CYCLES = 1037;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_READ    = 2'b01,
    OP_WRITE   = 2'b10,
    OP_REFRESH = 2'b11
  } ddr_op_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_t;

  // Address layout is {BA[1:0], row[12:0], col[8:0]}
  function automatic logic [DDR_ADDR_W-1:0] ddr_pack_addr(
    input logic [DDR_BA_W-1:0]  ba,
    input logic [DDR_ROW_W-1:0] row,
    input logic [DDR_COL_W-1:0] col
  );
    return {ba, row, col};
  endfunction

endpackage

// File: rtl/ddr_refresh_timer.sv
// Auto-refresh interval timer. Counts enabled cycles, ticks once per interval
// and latches a sticky overrun if an interval expires while the previous
// refresh has still not been handed to the controller.
module ddr_refresh_timer
  import ddr_pkg::*;
#(
  parameter int REFRESH_CYCLES = DDR_REFRESH_CYCLES
) (
  input  logic clk133_p,
  input  logic rst,
  input  logic i_enable,
  input  logic i_pending,
  output logic o_tick,
  output logic o_overrun
);

  localparam int CW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

  logic [CW-1:0] r_count;
  logic          r_overrun;

  assign o_tick    = i_enable && (r_count == LAST);
  assign o_overrun = r_overrun;

  // Interval counter: advances only while enabled, wraps at the last cycle
  always_ff @(posedge clk133_p) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_tick ? '0 : r_count + CW'(1);
    end
  end

  // Sticky overrun: a wrap while the earlier refresh is still waiting
  always_ff @(posedge clk133_p) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (o_tick && i_pending) begin
      r_overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/ddr_arbiter.sv
// DDR command arbiter: picks between auto-refresh, display reads and draw
// writes, presents one command at a time on a valid/ready command bus and
// waits for the controller to finish it before granting the next.
// Handshake: cmd_valid rises with the fields already stable; fields hold until
// a cycle with cmd_valid && cmd_ready, which is the single accept cycle and
// the cycle the winner's ack is high.
module ddr_arbiter
  import ddr_pkg::*;
#(
  parameter int REFRESH_CYCLES = DDR_REFRESH_CYCLES,
  parameter int STARVE_LIMIT   = 16
) (
  input  logic                  clk133_p,
  input  logic                  rst,
  input  logic                  init_done,
  input  logic                  disp_req,
  input  logic [DDR_ADDR_W-1:0] disp_addr,
  output logic                  disp_ack,
  output logic [DDR_DATA_W-1:0] disp_rdata,
  output logic                  disp_rvalid,
  input  logic                  draw_req,
  input  logic [DDR_ADDR_W-1:0] draw_addr,
  input  logic [DDR_DATA_W-1:0] draw_wdata,
  output logic                  draw_ack,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [1:0]            cmd_op,
  output logic [DDR_ADDR_W-1:0] cmd_addr,
  output logic [DDR_DATA_W-1:0] cmd_wdata,
  input  logic                  ctl_done,
  input  logic [DDR_DATA_W-1:0] ctl_rdata,
  input  logic                  ctl_rvalid,
  output logic                  refresh_overrun,
  output logic [1:0]            o_dbg_state
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t            r_state;
  logic                  r_cmd_valid;
  ddr_op_t               r_cmd_op;
  logic [DDR_ADDR_W-1:0] r_cmd_addr;
  logic [DDR_DATA_W-1:0] r_cmd_wdata;
  logic                  r_refresh_pending;
  logic [SW-1:0]         r_starve;
  logic                  r_disp_rvalid;
  logic [DDR_DATA_W-1:0] r_disp_rdata;

  logic w_accept;
  logic w_ref_hs;
  logic w_tick;
  logic w_read_window;
  logic w_grant_ref;
  logic w_grant_draw;
  logic w_grant_disp;

  assign w_accept      = r_cmd_valid && cmd_ready;
  assign w_ref_hs      = w_accept && (r_cmd_op == OP_REFRESH);
  assign w_read_window = (r_state == ST_WAIT_DONE) && (r_cmd_op == OP_READ);

  assign cmd_valid       = r_cmd_valid;
  assign cmd_op          = r_cmd_op;
  assign cmd_addr        = r_cmd_addr;
  assign cmd_wdata       = r_cmd_wdata;
  assign disp_rvalid     = r_disp_rvalid;
  assign disp_rdata      = r_disp_rdata;
  assign o_dbg_state     = r_state;
  // Acks mark the accept cycle; a reset in that cycle abandons the command
  assign disp_ack        = w_accept && (r_cmd_op == OP_READ) && !rst;
  assign draw_ack        = w_accept && (r_cmd_op == OP_WRITE) && !rst;

  ddr_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_refresh_timer (
    .clk133_p (clk133_p),
    .rst      (rst),
    .i_enable (init_done),
    .i_pending(r_refresh_pending && !w_ref_hs),
    .o_tick   (w_tick),
    .o_overrun(refresh_overrun)
  );

  // Grant priority in IDLE: refresh, starved draw, display, draw
  always_comb begin
    w_grant_ref  = 1'b0;
    w_grant_draw = 1'b0;
    w_grant_disp = 1'b0;
    if (r_state == ST_IDLE && init_done) begin
      if (r_refresh_pending)                      w_grant_ref  = 1'b1;
      else if (draw_req && r_starve == STARVE_MAX) w_grant_draw = 1'b1;
      else if (disp_req)                          w_grant_disp = 1'b1;
      else if (draw_req)                          w_grant_draw = 1'b1;
    end
  end

  // Command FSM: latch the winner, offer it, then wait for completion
  always_ff @(posedge clk133_p) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= OP_NOP;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_ref) begin
            r_cmd_op    <= OP_REFRESH;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
          end else if (w_grant_draw) begin
            r_cmd_op    <= OP_WRITE;
            r_cmd_addr  <= draw_addr;
            r_cmd_wdata <= draw_wdata;
          end else if (w_grant_disp) begin
            r_cmd_op    <= OP_READ;
            r_cmd_addr  <= disp_addr;
            r_cmd_wdata <= '0;
          end
          if (w_grant_ref || w_grant_draw || w_grant_disp) begin
            r_cmd_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_state     <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (ctl_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Refresh pending: set by a timer wrap, cleared when the refresh is accepted
  always_ff @(posedge clk133_p) begin
    if (rst) begin
      r_refresh_pending <= 1'b0;
    end else if (w_tick) begin
      r_refresh_pending <= 1'b1;
    end else if (w_ref_hs) begin
      r_refresh_pending <= 1'b0;
    end
  end

  // Starve counter: display grants taken while a draw write is waiting
  always_ff @(posedge clk133_p) begin
    if (rst) begin
      r_starve <= '0;
    end else if (!draw_req || w_grant_draw) begin
      r_starve <= '0;
    end else if (w_grant_disp && r_starve != STARVE_MAX) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  // Read return: pass controller data through only while a READ is outstanding
  always_ff @(posedge clk133_p) begin
    if (rst) begin
      r_disp_rvalid <= 1'b0;
      r_disp_rdata  <= '0;
    end else begin
      r_disp_rvalid <= w_read_window && ctl_rvalid;
      if (w_read_window && ctl_rvalid) r_disp_rdata <= ctl_rdata;
    end
  end

endmodule
